// File: rtl/md_stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// md_stall_ctrl_pkg
//
// Shared constants for the multiply/divide unit (MDU) sequencing logic.
// Used by the stall controller, and also by the MDU datapath and the
// decode unit, so the op codes and default latencies are defined only here.
//
// Contents:
//   MD_MULTU/MD_MULT/MD_DIVU/MD_DIV  2-bit MDU op codes carried on E_md_op
//   DEFAULT_MUL_CYCLES              busy cycles for mult/multu after issue
//   DEFAULT_DIV_CYCLES              busy cycles for div/divu after issue
//   CNT_W, CNT_MAX                  busy counter width and largest latency
//   md_state_e                      MDU occupancy FSM states
//   md_op_is_div()                  true for the divide-class op codes
// -----------------------------------------------------------------------------
package md_stall_ctrl_pkg;

    // MDU op codes. Bit 1 separates the divide class from the multiply class.
    localparam logic [1:0] MD_MULTU = 2'd0;
    localparam logic [1:0] MD_MULT  = 2'd1;
    localparam logic [1:0] MD_DIVU  = 2'd2;
    localparam logic [1:0] MD_DIV   = 2'd3;

    // Default MDU latencies, counted in cycles after the issue cycle.
    localparam int DEFAULT_MUL_CYCLES = 5;
    localparam int DEFAULT_DIV_CYCLES = 10;

    // The busy counter is 4 bits wide, so no latency may exceed 15.
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // MDU occupancy states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_BUSY = 2'd1,
        ST_DIV_BUSY = 2'd2
    } md_state_e;

    // Divide-class ops load the divide latency; everything else is a multiply.
    function automatic logic md_op_is_div(input logic [1:0] op);
        return (op == MD_DIVU) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/md_stall_ctrl_busy_fsm.sv
// -----------------------------------------------------------------------------
// md_busy_fsm
//
// MDU occupancy tracker. It leaves IDLE when an MDU op is started, then stays
// busy for exactly MUL_CYCLES or DIV_CYCLES cycles and returns to IDLE on
// its own. A start that arrives while the unit is busy is ignored: the
// counter is not reloaded. The surrounding stall logic normally keeps that
// from happening.
//
// Parameters:
//   MUL_CYCLES  busy cycles for mult/multu (1..15)
//   DIV_CYCLES  busy cycles for div/divu   (1..15)
//
// Ports:
//   clk       in   system clock, all state updates on posedge
//   reset     in   synchronous, active-high reset
//   start     in   E-stage instruction is an MDU op this cycle
//   op        in   MDU op code, valid with start
//   busy      out  MDU computing (state != IDLE, from registered state)
//   md_done   out  high in the last busy cycle
//   issue     out  start accepted this cycle (start while IDLE)
// -----------------------------------------------------------------------------
module md_busy_fsm
    import md_stall_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = DEFAULT_MUL_CYCLES,
    parameter int DIV_CYCLES = DEFAULT_DIV_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    output logic       busy,
    output logic       md_done,
    output logic       issue
);

    // Latencies that do not fit the 4-bit counter are rejected at elaboration.
    if (MUL_CYCLES < 1 || MUL_CYCLES > CNT_MAX) begin : g_bad_mul_cycles
        $error("md_busy_fsm: MUL_CYCLES must lie in 1..%0d", CNT_MAX);
    end
    if (DIV_CYCLES < 1 || DIV_CYCLES > CNT_MAX) begin : g_bad_div_cycles
        $error("md_busy_fsm: DIV_CYCLES must lie in 1..%0d", CNT_MAX);
    end

    localparam logic [CNT_W-1:0] MUL_CNT  = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State register. Reset wins over everything, so an operation cut short
    // by reset ends without ever passing through its md_done cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. cnt holds the number of busy cycles still to run,
    // including the current one. cnt == 1 is therefore the final busy cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (md_op_is_div(op)) begin
                        state_d = ST_DIV_BUSY;
                        cnt_d   = DIV_CNT;
                    end else begin
                        state_d = ST_MUL_BUSY;
                        cnt_d   = MUL_CNT;
                    end
                end
            end
            ST_MUL_BUSY,
            ST_DIV_BUSY: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Outputs come from the registered state, so busy and md_done do not
    // depend on any input in the current cycle.
    always_comb begin
        busy    = 1'b0;
        md_done = 1'b0;
        issue   = 1'b0;
        busy    = (state_q != ST_IDLE);
        md_done = (state_q != ST_IDLE) && (cnt_q == CNT_ONE);
        issue   = (state_q == ST_IDLE) && start;
    end

endmodule

// File: rtl/md_stall_ctrl.sv
// -----------------------------------------------------------------------------
// md_stall_ctrl
//
// Sequencing controller for the MDU and the front-end pipeline registers of
// the 5-stage core. It combines the hazard unit's RAW stall request with the
// MDU occupancy. An MDU-class instruction in D (mult/div/mfhi/mflo/mthi/mtlo)
// is held while the MDU is busy, and also in the cycle where an MDU op is
// issued from E. Non-MDU instructions continue while the MDU is busy.
//
// Optional feature (macro MD_STALL_STAT_EN):
//   stall_cnt     cycles where an MDU-class D instruction was held by the MDU
//                 (cycles stalled only by D_data_stall are not counted)
//   md_issue_cnt  accepted MDU starts
//   Both counters saturate at all-ones and are cleared by reset. When the
//   macro is undefined, both ports and both counters are absent.
//
// Parameters:
//   MUL_CYCLES  busy cycles for mult/multu after issue (1..15)
//   DIV_CYCLES  busy cycles for div/divu after issue   (1..15)
//
// Ports:
//   clk           in   system clock
//   reset         in   synchronous, active-high reset
//   E_md_start    in   E-stage instruction is mult/multu/div/divu
//   E_md_op       in   E-stage MDU op code
//   D_use_md      in   D-stage instruction is MDU-class
//   D_data_stall  in   RAW stall request from the hazard unit
//   busy          out  MDU computing
//   md_done       out  pulse in the last busy cycle
//   PC_WE         out  PC write-enable
//   FD_WE         out  F/D register write-enable
//   DE_flush      out  D/E bubble insert
//   stall         out  combined stall
// -----------------------------------------------------------------------------
module md_stall_ctrl
    import md_stall_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = DEFAULT_MUL_CYCLES,
    parameter int DIV_CYCLES = DEFAULT_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_md_start,
    input  logic [1:0]  E_md_op,
    input  logic        D_use_md,
    input  logic        D_data_stall,
    output logic        busy,
    output logic        md_done,
    output logic        PC_WE,
    output logic        FD_WE,
    output logic        DE_flush,
    output logic        stall
`ifdef MD_STALL_STAT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] md_issue_cnt
`endif
);

    logic fsm_busy;
    logic fsm_done;
    logic fsm_issue;
    logic md_hold;

    md_busy_fsm #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_busy_fsm (
        .clk     (clk),
        .reset   (reset),
        .start   (E_md_start),
        .op      (E_md_op),
        .busy    (fsm_busy),
        .md_done (fsm_done),
        .issue   (fsm_issue)
    );

    // Stall merge. md_hold is the MDU's share of the stall. The E_md_start
    // term holds a D-stage MDU instruction in the issue cycle, before busy
    // has risen. During reset, only the hazard unit's request can stall the
    // front end.
    always_comb begin
        md_hold  = 1'b0;
        stall    = 1'b0;
        md_hold  = D_use_md && (fsm_busy || E_md_start) && !reset;
        stall    = D_data_stall || md_hold;
        busy     = fsm_busy;
        md_done  = fsm_done;
        PC_WE    = !stall;
        FD_WE    = !stall;
        DE_flush = stall;
    end

`ifdef MD_STALL_STAT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] md_issue_cnt_q, md_issue_cnt_d;

    // Saturating event counters. Only md_hold cycles are counted, so stalls
    // caused solely by the hazard unit do not change stall_cnt.
    always_comb begin
        stall_cnt_d    = stall_cnt_q;
        md_issue_cnt_d = md_issue_cnt_q;
        if (md_hold && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (fsm_issue && (md_issue_cnt_q != 32'hFFFF_FFFF)) begin
            md_issue_cnt_d = md_issue_cnt_q + 32'd1;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q    <= 32'd0;
            md_issue_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q    <= stall_cnt_d;
            md_issue_cnt_q <= md_issue_cnt_d;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign md_issue_cnt = md_issue_cnt_q;
`endif

endmodule

// File: tb/tb_md_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_md_stall_ctrl
//
// Testbench for md_stall_ctrl. It uses two instances: one with default
// latencies and one with MUL_CYCLES=1. The reference model tracks the number
// of busy cycles still to run as a plain integer for each instance, and it
// derives the stall from the pipeline rules.
// -----------------------------------------------------------------------------
module tb_md_stall_ctrl;
    import md_stall_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       E_md_start;
    logic [1:0] E_md_op;
    logic       D_use_md;
    logic       D_data_stall;

    logic busy, md_done, PC_WE, FD_WE, DE_flush, stall;
    logic busyB, mdDoneB, pcWeB, fdWeB, deFlushB, stallB;
`ifdef MD_STALL_STAT_EN
    logic [31:0] stall_cnt, md_issue_cnt, stallCntB, issueCntB;
    logic [31:0] expStallCnt, expIssueCnt;
`endif

    int checks = 0;
    int errors = 0;

    // Busy cycles still to run, counting the current cycle.
    int remA = 0;
    int remB = 0;

    logic lastStall, lastBusy, lastDone, lastStallB, lastBusyB, lastDoneB;

    md_stall_ctrl uDut (
        .clk          (clk),
        .reset        (reset),
        .E_md_start   (E_md_start),
        .E_md_op      (E_md_op),
        .D_use_md     (D_use_md),
        .D_data_stall (D_data_stall),
        .busy         (busy),
        .md_done      (md_done),
        .PC_WE        (PC_WE),
        .FD_WE        (FD_WE),
        .DE_flush     (DE_flush),
        .stall        (stall)
`ifdef MD_STALL_STAT_EN
        ,
        .stall_cnt    (stall_cnt),
        .md_issue_cnt (md_issue_cnt)
`endif
    );

    md_stall_ctrl #(.MUL_CYCLES(1)) uMul1 (
        .clk          (clk),
        .reset        (reset),
        .E_md_start   (E_md_start),
        .E_md_op      (E_md_op),
        .D_use_md     (D_use_md),
        .D_data_stall (D_data_stall),
        .busy         (busyB),
        .md_done      (mdDoneB),
        .PC_WE        (pcWeB),
        .FD_WE        (fdWeB),
        .DE_flush     (deFlushB),
        .stall        (stallB)
`ifdef MD_STALL_STAT_EN
        ,
        .stall_cnt    (stallCntB),
        .md_issue_cnt (issueCntB)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct packed {
        logic       rst;
        logic       start;
        logic [1:0] op;
        logic       useMd;
        logic       ds;
        logic       eBusy;
        logic       eDone;
        logic       eStall;
    } vec_t;

    vec_t vecs [12];

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0b expected %0b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic checkWord(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic start, input logic [1:0] op,
                                 input logic useMd, input logic ds);
        @(negedge clk);
        reset        = rst;
        E_md_start   = start;
        E_md_op      = op;
        D_use_md     = useMd;
        D_data_stall = ds;
    endtask

    task automatic checkOutput(input logic eBusy, input logic eDone, input logic eStall,
                               input string tag);
        checkBit({tag, " busy"},     busy,     eBusy);
        checkBit({tag, " md_done"},  md_done,  eDone);
        checkBit({tag, " stall"},    stall,    eStall);
        checkBit({tag, " PC_WE"},    PC_WE,    !eStall);
        checkBit({tag, " FD_WE"},    FD_WE,    !eStall);
        checkBit({tag, " DE_flush"}, DE_flush, eStall);
    endtask

    // An MDU-class instruction in D is held while the MDU is occupied or
    // being issued. The hazard unit's request always stalls.
    function automatic logic modelStall(input int rem);
        return D_data_stall || (!reset && D_use_md && (rem > 0 || E_md_start));
    endfunction

    function automatic int modelNext(input int rem, input int mulN);
        if (reset)      return 0;
        if (rem > 0)    return rem - 1;
        if (E_md_start) return E_md_op[1] ? DEFAULT_DIV_CYCLES : mulN;
        return 0;
    endfunction

    task automatic checkModel(input string tag);
        checkOutput(remA > 0, remA == 1, modelStall(remA), tag);
        checkBit({tag, " B busy"},    busyB,   remB > 0);
        checkBit({tag, " B md_done"}, mdDoneB, remB == 1);
        checkBit({tag, " B stall"},   stallB,  modelStall(remB));
        checkBit({tag, " B PC_WE"},   pcWeB,   !modelStall(remB));
`ifdef MD_STALL_STAT_EN
        checkWord({tag, " stall_cnt"},    stall_cnt,    expStallCnt);
        checkWord({tag, " md_issue_cnt"}, md_issue_cnt, expIssueCnt);
`endif
    endtask

    // Advance the model across the rising edge using the inputs held there.
    task automatic modelEdge();
        @(posedge clk);
`ifdef MD_STALL_STAT_EN
        if (reset) begin
            expStallCnt = 0;
            expIssueCnt = 0;
        end else begin
            if (D_use_md && (remA > 0 || E_md_start) && expStallCnt != 32'hFFFF_FFFF)
                expStallCnt = expStallCnt + 1;
            if (remA == 0 && E_md_start && expIssueCnt != 32'hFFFF_FFFF)
                expIssueCnt = expIssueCnt + 1;
        end
`endif
        remA = modelNext(remA, DEFAULT_MUL_CYCLES);
        remB = modelNext(remB, 1);
    endtask

    task automatic runCycle(input logic rst, input logic start, input logic [1:0] op,
                            input logic useMd, input logic ds, input string tag);
        applyStimulus(rst, start, op, useMd, ds);
        #1;
        checkModel(tag);
        lastStall  = stall;
        lastBusy   = busy;
        lastDone   = md_done;
        lastStallB = stallB;
        lastBusyB  = busyB;
        lastDoneB  = mdDoneB;
        modelEdge();
    endtask

    task automatic drain();
        for (int i = 0; i < 12; i++) runCycle(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "drain");
    endtask

    initial begin
        int stallCount;
        int busyCount;
        int doneCount;

        reset = 1'b1; E_md_start = 1'b0; E_md_op = 2'd0; D_use_md = 1'b0; D_data_stall = 1'b0;
`ifdef MD_STALL_STAT_EN
        expStallCnt = 0;
        expIssueCnt = 0;
`endif
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        modelEdge();
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        modelEdge();

        // Fields: rst start op useMd ds | busy done stall
        vecs[0]  = '{1'b0, 1'b1, MD_MULT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 2'd0,    1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 2'd0,    1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 2'd0,    1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 2'd0,    1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 2'd0,    1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 2'd0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 2'd0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 2'd0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 2'd0,    1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b1, MD_MULT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 2'd0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].start, vecs[i].op, vecs[i].useMd, vecs[i].ds);
            #1;
            checkOutput(vecs[i].eBusy, vecs[i].eDone, vecs[i].eStall, $sformatf("vec%0d", i));
`ifdef MD_STALL_STAT_EN
            if (i == 6) begin
                checkWord("vec6 stall_cnt after mult+mflo", stall_cnt, 32'd6);
                checkWord("vec6 md_issue_cnt after mult", md_issue_cnt, 32'd1);
            end
`endif
            modelEdge();
        end

        // div issued with addu in D, then mfhi arrives in busy cycle 4.
        runCycle(1'b0, 1'b1, MD_DIV, 1'b0, 1'b0, "div issue");
        checkBit("div issue stall", lastStall, 1'b0);
        stallCount = 0;
        busyCount  = 0;
        doneCount  = 0;
        for (int k = 1; k <= 12; k++) begin
            runCycle(1'b0, 1'b0, 2'd0, (k >= 4 && k <= 10), 1'b0, $sformatf("div k%0d", k));
            stallCount += int'(lastStall);
            busyCount  += int'(lastBusy);
            doneCount  += int'(lastDone);
        end
        checkWord("div busy cycles", busyCount, 32'd10);
        checkWord("div mfhi stall cycles", stallCount, 32'd7);
        checkWord("div md_done pulses", doneCount, 32'd1);
        drain();

        // divu cut short by reset in busy cycle 3.
        runCycle(1'b0, 1'b1, MD_DIVU, 1'b0, 1'b0, "divu issue");
        runCycle(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "divu b1");
        runCycle(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "divu b2");
        runCycle(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, "divu reset b3");
        runCycle(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, "after reset");
        checkBit("after reset busy", lastBusy, 1'b0);
        checkBit("after reset md_done", lastDone, 1'b0);
        checkBit("after reset D_use_md stall", lastStall, 1'b0);
        drain();

        // MUL_CYCLES=1 instance: a single busy cycle that is also the done cycle.
        runCycle(1'b0, 1'b1, MD_MULT, 1'b0, 1'b0, "m1 issue");
        runCycle(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "m1 busy");
        checkBit("m1 busy cycle busy", lastBusyB, 1'b1);
        checkBit("m1 busy cycle md_done", lastDoneB, 1'b1);
        runCycle(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "m1 after");
        checkBit("m1 after busy", lastBusyB, 1'b0);
        drain();

        // Back-to-back mult on the MUL_CYCLES=1 instance: the second mult
        // waits in D through the issue cycle and the single busy cycle.
        stallCount = 0;
        runCycle(1'b0, 1'b1, MD_MULT, 1'b1, 1'b0, "b2b c0");
        stallCount += int'(lastStallB);
        runCycle(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, "b2b c1");
        stallCount += int'(lastStallB);
        runCycle(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, "b2b c2");
        stallCount += int'(lastStallB);
        checkWord("m1 back-to-back stall cycles", stallCount, 32'd2);
        drain();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            runCycle($urandom_range(63) == 0, $urandom_range(3) == 0, 2'($urandom_range(3)),
                     1'($urandom_range(1)), $urandom_range(4) == 0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_stall_ctrl.md
Name: md_stall_ctrl

Overview:
- Sequencing controller for the multiply/divide unit (MDU) and the front-end pipeline registers of the 5-stage MIPS core.
- Tracks MDU occupancy with a small FSM and cycle counter.
- Merges the MDU busy condition with the data-hazard stall request from the hazard unit.
- Drives the write-enables for PC and F/D, plus the bubble-insert flush for D/E, so MDU-class instructions in D wait until the MDU is free.

Parameters:
- MUL_CYCLES, 5, busy cycles for mult/multu after issue (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu after issue (legal range 1..15)

Ports:
- clk  in  1  system clock, all state updates on posedge
- reset  in  1  synchronous, active-high reset
- E_md_start  in  1  E-stage instruction is mult/multu/div/divu this cycle
- E_md_op  in  2  E-stage MDU op: 0 multu, 1 mult, 2 divu, 3 div (valid with E_md_start)
- D_use_md  in  1  D-stage instruction is MDU-class (mult/multu/div/divu/mfhi/mflo/mthi/mtlo)
- D_data_stall  in  1  RAW stall request from hazard unit (combinational)
- busy  out  1  MDU computing (registered, state != IDLE)
- md_done  out  1  single-cycle pulse in the last busy cycle
- PC_WE  out  1  PC write-enable
- FD_WE  out  1  F/D register write-enable
- DE_flush  out  1  D/E register bubble insert (clears to nop next edge)
- stall  out  1  combined stall, for debug/visibility

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high (reset); no asynchronous paths.
- FSM states: IDLE, MUL_BUSY, DIV_BUSY. State encoding and cnt[3:0] are internal.
- Reset: state=IDLE, cnt=0, busy=0, md_done=0. Outputs during reset: stall=D_data_stall (D_use_md term gated off), PC_WE=FD_WE=~stall, DE_flush=stall.
- IDLE, on posedge with E_md_start=1:
  - E_md_op[1]=0: go to MUL_BUSY, cnt<=MUL_CYCLES.
  - E_md_op[1]=1: go to DIV_BUSY, cnt<=DIV_CYCLES.
- MUL_BUSY/DIV_BUSY, each posedge: cnt<=cnt-1. When cnt==1, go to IDLE and cnt<=0.
- Latency: busy is high for exactly N cycles after the issue cycle (N=MUL_CYCLES or DIV_CYCLES). md_done=1 iff state!=IDLE and cnt==1 (combinational from registered state).
- E_md_start while busy: ignored, no restart, no counter reload. This cannot occur legally because the stall blocks it. A simulation-only $display warning is permitted.
- Stall equation (combinational): stall = D_data_stall | (D_use_md & (busy | E_md_start)).
  - The E_md_start term stalls a D-stage MDU instruction in the issue cycle itself.
  - Consequence: mult followed immediately by mflo gives 1+N stall cycles.
- PC_WE=~stall; FD_WE=~stall; DE_flush=stall.
- A non-MDU instruction in D while busy proceeds with no stall.
- mthi/mtlo/mfhi/mflo never start the FSM; they only stall while busy or in the issue cycle.
- Reset mid-operation: returns to IDLE on that edge, cnt=0, no md_done pulse.
- cnt width is 4 bits. Parameters outside 1..15 are illegal (elaboration-time check).

Optional Feature:
- Macro: MD_STALL_STAT_EN
- Defined:
  - Adds output stall_cnt (32 bits): counts cycles where D_use_md & (busy | E_md_start), excluding cycles caused only by D_data_stall.
  - Saturates at 32'hFFFF_FFFF; cleared by reset.
  - Adds output md_issue_cnt (32 bits): increments on each accepted start, same saturation and reset.
- Undefined: both ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/header: MDU op codes (MD_MULTU=0, MD_MULT=1, MD_DIVU=2, MD_DIV=3), FSM state constants, default MUL_CYCLES/DIV_CYCLES.
- These constants are reused by the MDU datapath and the decode unit.
- One natural sub-module: md_busy_fsm (state + cnt + md_done).
- The stall merge stays as top-level combinational logic.

Test Plan:
- mult (op=1) issued, mflo in D the same cycle: stall high 6 consecutive cycles (issue + 5 busy), md_done pulses in the 5th busy cycle, PC_WE=0 throughout, mflo enters E on the 7th cycle.
- div (op=3) issued, then addu in D: no stall, busy high 10 cycles. Then mfhi in D at busy cycle 4: stall for the remaining 7 cycles.
- divu issued, reset asserted at busy cycle 3: next cycle state=IDLE, busy=0, no md_done. A D_use_md in the following cycle does not stall.
- D_data_stall=1 with MDU idle and D_use_md=0: stall=1, PC_WE=FD_WE=0, DE_flush=1. Deassert it: all outputs return to 1/1/0 the same cycle.
- MUL_CYCLES=1 override: mult issue, busy high 1 cycle with md_done high in that same cycle. Back-to-back mult in D stalls exactly 2 cycles.
- MD_STALL_STAT_EN defined: the first scenario gives stall_cnt=6 and md_issue_cnt=1. Cycles with only D_data_stall leave stall_cnt unchanged.
